// File: rtl/counter_pkg.sv
// Shared types and constants for the modulo counter.
// The boundary mode and the default counter width are kept here.
package counter_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/count_next.sv
// Combinational next-count and boundary detection for the modulo counter.
// The result depends only on the current count, the limit, the direction and the boundary mode.
module count_next
  import counter_pkg::*;
#(
  parameter int    WIDTH = DEFAULT_WIDTH,
  parameter mode_e MODE  = MODE_WRAP
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic [WIDTH-1:0] lim_i,
  input  logic             up_i,
  output logic [WIDTH-1:0] next_o,
  output logic             boundary_o
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    next_o     = count_i;
    boundary_o = 1'b0;
    if (up_i) begin
      // Counts above the limit are treated as having reached it.
      if (count_i >= lim_i) begin
        boundary_o = 1'b1;
        next_o     = (MODE == MODE_SAT) ? lim_i : '0;
      end else begin
        next_o = count_i + ONE;
      end
    end else begin
      if (count_i == '0) begin
        boundary_o = 1'b1;
        next_o     = (MODE == MODE_SAT) ? '0 : lim_i;
      end else if (count_i > lim_i) begin
        next_o = lim_i;
      end else begin
        next_o = count_i - ONE;
      end
    end
  end

endmodule

// File: rtl/mod_counter.sv
// Loadable up/down modulo counter with wrap or saturate behaviour at the limit.
// All state lives here; the next-count arithmetic comes from count_next.
module mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic             en,
  input  logic             up,
  input  logic [WIDTH-1:0] PI,
  input  logic [WIDTH-1:0] lim,
  output logic [WIDTH-1:0] C,
  output logic             cout,
  output logic             zero
);

  localparam mode_e MODE = (SATURATE != 0) ? MODE_SAT : MODE_WRAP;

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("mod_counter: WIDTH must be in the range 2..32");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             cout_q, cout_d;
  logic [WIDTH-1:0] stepValue;
  logic             stepBoundary;

  count_next #(
    .WIDTH(WIDTH),
    .MODE (MODE)
  ) u_count_next (
    .count_i   (count_q),
    .lim_i     (lim),
    .up_i      (up),
    .next_o    (stepValue),
    .boundary_o(stepBoundary)
  );

  // Priority below reset: clear, then load, then count; idle cycles drop cout.
  always_comb begin
    count_d = count_q;
    cout_d  = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (ld) begin
      count_d = PI;
    end else if (en) begin
      count_d = stepValue;
      cout_d  = stepBoundary;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      cout_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      cout_q  <= cout_d;
    end
  end

  assign C    = count_q;
  assign cout = cout_q;
  assign zero = (count_q == '0);

endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the counter, load and limit width (legal range 2..32).
REQ-002 Parameter SATURATE, default 0, SHALL select boundary behaviour: 0 = wrap, 1 = hold at boundary.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 clr  input  1  SHALL be a synchronous clear of the count to 0.
REQ-006 ld  input  1  SHALL be the parallel-load strobe.
REQ-007 en  input  1  SHALL be the count enable.
REQ-008 up  input  1  SHALL be the direction select: 1 = increment, 0 = decrement.
REQ-009 PI  input  WIDTH  SHALL be the parallel-load value.
REQ-010 lim  input  WIDTH  SHALL be the terminal value (modulus minus 1), sampled every cycle.
REQ-011 C  output  WIDTH  SHALL be the registered count.
REQ-012 cout  output  1  SHALL be a registered one-cycle boundary-event flag.
REQ-013 zero  output  1  SHALL be combinational (C == 0).

Function
REQ-014 Per-edge priority SHALL be rst > clr > ld > en; if none is active, C holds and cout <= 0.
REQ-015 clr SHALL set C <= 0 and cout <= 0, regardless of ld or en.
REQ-016 ld SHALL set C <= PI and cout <= 0, regardless of en; a PI value above lim SHALL be loaded unchanged.
REQ-017 Up-count: if C < lim, C <= C+1 and cout <= 0; if C >= lim, a boundary event occurs.
REQ-018 Up boundary event: with SATURATE=0, C <= 0; with SATURATE=1, C <= lim; in both modes cout <= 1.
REQ-019 Down-count: if 0 < C <= lim, C <= C-1 and cout <= 0; if C == 0, a boundary event occurs.
REQ-020 Down boundary event: with SATURATE=0, C <= lim; with SATURATE=1, C holds at 0; in both modes cout <= 1.
REQ-021 Down-count with C > lim SHALL set C <= lim and cout <= 0 (range recovery).
REQ-022 With SATURATE=1, cout SHALL reassert on every enabled cycle spent at the boundary in the active direction.
REQ-023 With lim == 0, every enabled cycle SHALL be a boundary event: C stays 0 and cout = 1.
REQ-024 With lim == 2^WIDTH-1, the counter SHALL behave as a full-range binary counter.
REQ-025 A change to up or lim SHALL take effect on the same edge it is sampled; no internal pipelining.
REQ-026 No arithmetic overflow SHALL reach C; all next-state values stay within WIDTH bits.

Reset
REQ-027 On rst at a rising edge, C <= 0 and cout <= 0; zero then reads 1.
REQ-028 rst asserted mid-count SHALL override clr, ld and en on that edge, with no residual cout.
REQ-029 C and cout SHALL have no asynchronous reset path; before the first reset edge their values are undefined.

Structure
REQ-030 The shared package counter_pkg SHALL hold the boundary-mode enum (MODE_WRAP, MODE_SAT) and the default WIDTH constant.
REQ-031 The next-count and boundary-detect logic SHALL be one combinational sub-module, count_next, instantiated once; all registers SHALL be in mod_counter.

Verification (WIDTH=4)
REQ-032 Wrap up: rst, lim=9, en=1, up=1 for 12 cycles -> C sequence 1..9,0,1,2; cout=1 exactly in the cycle C becomes 0.
REQ-033 Wrap down: ld PI=2, lim=5, up=0, en=1 for 4 cycles -> C = 1,0,5,4; cout=1 only when C becomes 5.
REQ-034 Saturate: SATURATE=1, lim=3, up=1, en=1 for 6 cycles from 0 -> C = 1,2,3,3,3,3; cout=1 on the last three cycles.
REQ-035 Priority: at one edge with C=7, assert clr=1, ld=1, PI=4, en=1 -> C=0, cout=0; next edge with ld=1 and en=1 -> C=4.
REQ-036 Out-of-range load: lim=5, ld PI=12, then up=1 en=1 -> C=0 with cout=1; repeat load with up=0 -> C=5 with cout=0.
REQ-037 Mid-operation reset: counting at C=6, assert rst together with ld=1, PI=9 -> C=0, cout=0, zero=1.
